w1_ram_loader: RTL and testbench
================================

# w1_ram_loader

Loadable weight store for conv layer 1. It accepts a byte stream of kernel weights over a valid/ready handshake and packs each group of six bytes (one byte per output channel) into a 48-bit word. It writes the packed word into a 25-entry memory and presents the same six-lane, one-cycle-latency read port the conv1 datapath already consumes. It sits between the host/DMA weight stream and the conv1 engine, so layer-1 weights can be reloaded at run time without resynthesis.

## Interface
- DEPTH, 25, words stored (5x5 kernel taps)
- ADDR_W, 5, address width; DEPTH <= 2**ADDR_W
- LANES, 6, bytes per word (conv1 output channels)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled in IDLE or DONE
- wr_data  in  8  weight byte
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  loader accepts a byte this cycle
- busy  out  1  high while in LOAD
- load_done  out  1  high in DONE (full table written)
- w1_raddr  in  ADDR_W  read address from conv1 controller
- w1_1_rdata .. w1_6_rdata  out  8 each  lane k = bits [8k-1:8k-8] of the word at w1_raddr

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start=1 -> LOAD.
  - LOAD: wr_ready=1, busy=1. Counters: byte_cnt (0..LANES-1) and word_addr (0..DEPTH-1), both cleared on entry.
  - DONE: load_done=1. start=1 -> LOAD (full reload, counters cleared).
- start while in LOAD is ignored.
- Transfer occurs only when wr_valid && wr_ready. No transfer means no counter change.
- Byte with byte_cnt=i goes to pack-register lane i (bits [8i+7:8i]).
  - So the first byte of each group drives w1_1_rdata and the sixth drives w1_6_rdata.
- Sixth byte (byte_cnt=LANES-1) accepted:
  - Write word {byte5,...,byte0} to mem[word_addr] in that same cycle; the last byte is bypassed directly into the write data.
  - byte_cnt -> 0 and word_addr increments.
- Write at word_addr=DEPTH-1 -> next state DONE; wr_ready drops the following cycle.
- Bytes beyond DEPTH*LANES are not accepted (wr_ready=0 outside LOAD).
- Read port is always active, independent of FSM state.
  - Registered output: rdata <= (w1_raddr < DEPTH) ? mem[w1_raddr] : 0.
- Read and write to the same address in the same cycle: the read returns the old contents (read-first).
- Memory is not cleared by rst. Contents before the first completed load are undefined to the consumer; the consumer must wait for load_done.
- Reset mid-load:
  - FSM -> IDLE, counters and pack register cleared.
  - Words already written stay in memory; the partial group is discarded.

## Timing
- Reset values: wr_ready=0, busy=0, load_done=0, all w1_k_rdata=0, state=IDLE.
- start sampled at edge N -> busy=1 and wr_ready=1 from cycle N+1.
- Full load with wr_valid held high takes exactly DEPTH*LANES = 150 accepted cycles.
  - load_done=1 and busy=0 on the cycle after the 150th transfer.
- Read latency is 1 cycle: address at edge N, data valid after edge N+1 (matches existing conv1 ROM timing).
- Write on edge N is visible to a read addressed at edge N+1 or later.
- wr_ready is a registered function of state only; it does not depend on wr_valid combinationally.

## Test plan
- Reset then idle: assert rst 2 cycles, hold w1_raddr=0 -> all rdata=0, wr_ready=0, load_done=0; wr_valid pulses without start produce no writes.
- Full load, continuous: start, stream bytes 0x00..0x95 with wr_valid=1 -> load_done after 150 transfers; read addr 0 -> lanes 1..6 = 0x00..0x05; addr 24 -> 0x90..0x95.
- Throttled stream: random wr_valid gaps (~40% duty) with the same data -> identical memory image; byte count and handshake correct, with no lost or duplicated bytes.
- Out-of-range read and collision: read addr 25 and 31 -> all lanes 0. During a reload, read addr 3 in the same cycle the word for addr 3 is written -> old value; the next cycle returns the new value.
- Reset mid-load: reset after 40 bytes (words 0..5 written, 4 bytes pending) -> IDLE, wr_ready=0. Then start and reload with 0xFF-pattern -> all 25 words correct, load_done=1.
- Reload from DONE: start in DONE with a new stream -> busy=1 next cycle, load_done=0; after 150 bytes the new image is fully replaced. A start pulse asserted mid-LOAD has no effect on the counters.

Source files
------------

// File: rtl/w1_ram_loader.sv
// w1_ram_loader: run-time loadable weight store for conv layer 1.
// A byte stream arrives over wr_valid/wr_ready. Every LANES bytes are packed
// into one word (first byte in lane 0) and written to a DEPTH-entry memory.
// The memory also has a registered, read-first read port that feeds the conv1
// datapath with one cycle of latency.
module w1_ram_loader #(
   parameter int DEPTH  = 25,
   parameter int ADDR_W = 5,
   parameter int LANES  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              busy,
   output logic              load_done,
   input  logic [ADDR_W-1:0] w1_raddr,
   output logic [7:0]        w1_1_rdata,
   output logic [7:0]        w1_2_rdata,
   output logic [7:0]        w1_3_rdata,
   output logic [7:0]        w1_4_rdata,
   output logic [7:0]        w1_5_rdata,
   output logic [7:0]        w1_6_rdata
);

   localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int WORD_W = 8 * LANES;

   localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(LANES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W:0]   DEPTH_LIM  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_next_s;
   logic [CNT_W-1:0]    byte_cnt_r;
   logic [ADDR_W-1:0]   word_addr_r;
   logic [WORD_W-1:0]   pack_r;
   logic [WORD_W-1:0]   mem_r [DEPTH];
   logic [WORD_W-1:0]   rdata_r;
   logic                wr_ready_r;
   logic                busy_r;
   logic                done_r;

   logic                xfer_s;
   logic                last_byte_s;
   logic                we_s;
   logic                enter_load_s;
   logic                rd_in_range_s;
   logic [WORD_W-1:0]   wdata_s;

   // Handshake decode and write-word assembly (last byte bypasses the pack register).
   always_comb begin
      xfer_s        = wr_valid && wr_ready_r;
      last_byte_s   = (byte_cnt_r == LAST_BYTE);
      we_s          = xfer_s && last_byte_s;
      enter_load_s  = (state_r != ST_LOAD) && (state_next_s == ST_LOAD);
      rd_in_range_s = ({1'b0, w1_raddr} < DEPTH_LIM);
      wdata_s       = pack_r;
      wdata_s[WORD_W-1 -: 8] = wr_data;
   end

   // Next-state logic; start is only honoured outside LOAD.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_LOAD;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (we_s && (word_addr_r == LAST_ADDR)) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_LOAD;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_next_s = ST_LOAD;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register plus status outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         wr_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         wr_ready_r <= (state_next_s == ST_LOAD);
         busy_r     <= (state_next_s == ST_LOAD);
         done_r     <= (state_next_s == ST_DONE);
      end
   end

   // Byte/word counters and pack register; cleared on reset and on every LOAD entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_r  <= {CNT_W{1'b0}};
         word_addr_r <= {ADDR_W{1'b0}};
         pack_r      <= {WORD_W{1'b0}};
      end else if (enter_load_s) begin
         byte_cnt_r  <= {CNT_W{1'b0}};
         word_addr_r <= {ADDR_W{1'b0}};
         pack_r      <= {WORD_W{1'b0}};
      end else if (xfer_s) begin
         pack_r[{byte_cnt_r, 3'b000} +: 8] <= wr_data;
         if (last_byte_s) begin
            byte_cnt_r <= {CNT_W{1'b0}};
            if (word_addr_r == LAST_ADDR) begin
               word_addr_r <= {ADDR_W{1'b0}};
            end else begin
               word_addr_r <= word_addr_r + ADDR_ONE;
            end
         end else begin
            byte_cnt_r  <= byte_cnt_r + CNT_ONE;
            word_addr_r <= word_addr_r;
         end
      end else begin
         byte_cnt_r  <= byte_cnt_r;
         word_addr_r <= word_addr_r;
         pack_r      <= pack_r;
      end
   end

   // Weight memory write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_r[word_addr_r] <= wdata_s;
      end
   end

   // Registered read-first read port; out-of-range addresses return zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= {WORD_W{1'b0}};
      end else if (rd_in_range_s) begin
         rdata_r <= mem_r[w1_raddr];
      end else begin
         rdata_r <= {WORD_W{1'b0}};
      end
   end

   assign wr_ready   = wr_ready_r;
   assign busy       = busy_r;
   assign load_done  = done_r;
   assign w1_1_rdata = rdata_r[7:0];
   assign w1_2_rdata = rdata_r[15:8];
   assign w1_3_rdata = rdata_r[23:16];
   assign w1_4_rdata = rdata_r[31:24];
   assign w1_5_rdata = rdata_r[39:32];
   assign w1_6_rdata = rdata_r[47:40];

endmodule

// File: tb/tb_w1_ram_loader.sv
// Testbench for w1_ram_loader: random-throttled byte streams checked against a
// byte-queue model of the weight table.
module tb_w1_ram_loader;

   localparam int DEPTH = 25;
   localparam int NBYTES = 150;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic       busy;
   logic       load_done;
   logic [4:0] w1_raddr;
   logic [7:0] w1_1_rdata, w1_2_rdata, w1_3_rdata, w1_4_rdata, w1_5_rdata, w1_6_rdata;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  img [NBYTES];
   logic [47:0] model_mem [DEPTH];
   logic [7:0]  grp_q [$];
   int          model_wr = 0;

   w1_ram_loader dut (
      .clk(clk), .rst(rst), .start(start), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .busy(busy), .load_done(load_done), .w1_raddr(w1_raddr),
      .w1_1_rdata(w1_1_rdata), .w1_2_rdata(w1_2_rdata), .w1_3_rdata(w1_3_rdata),
      .w1_4_rdata(w1_4_rdata), .w1_5_rdata(w1_5_rdata), .w1_6_rdata(w1_6_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: six accepted bytes form one word, first byte in the lowest lane
   task automatic model_accept(input logic [7:0] b);
      logic [47:0] w;
      grp_q.push_back(b);
      if (grp_q.size() == 6) begin
         w = 48'h0;
         for (int k = 0; k < 6; k++) w[8*k +: 8] = grp_q[k];
         if (model_wr < DEPTH) model_mem[model_wr] = w;
         model_wr++;
         grp_q.delete();
      end
   endtask

   task automatic model_restart();
      grp_q.delete();
      model_wr = 0;
   endtask

   task automatic read_word(input logic [4:0] a, output logic [47:0] d);
      @(negedge clk);
      w1_raddr = a;
      @(negedge clk);
      d = {w1_6_rdata, w1_5_rdata, w1_4_rdata, w1_3_rdata, w1_2_rdata, w1_1_rdata};
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_restart();
   endtask

   // drive img[first..last-1]; wr_valid asserted with probability duty %
   task automatic send_stream(input int first, input int last, input int duty,
                              output int cycles, output bit early, output bit tmo);
      int idx = first;
      cycles = 0;
      early = 1'b0;
      tmo = 1'b0;
      while (idx < last) begin
         @(negedge clk);
         if (load_done) early = 1'b1;
         if (cycles > 3000) begin
            tmo = 1'b1;
            break;
         end
         cycles++;
         wr_valid = ($urandom_range(99) < duty);
         wr_data  = wr_valid ? img[idx] : 8'($urandom);
         if (wr_valid && wr_ready) begin
            model_accept(img[idx]);
            idx++;
         end
      end
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic seen;
      rst = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; w1_raddr = 5'd0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({w1_6_rdata, w1_5_rdata, w1_4_rdata, w1_3_rdata, w1_2_rdata, w1_1_rdata} !== 48'h0) begin
         n_errors++;
         $display("FAIL reset_rdata: got %h expected 0", {w1_6_rdata, w1_5_rdata, w1_4_rdata, w1_3_rdata, w1_2_rdata, w1_1_rdata});
      end
      n_checks++;
      if ({wr_ready, busy, load_done} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_status: got ready/busy/done=%b expected 000", {wr_ready, busy, load_done});
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         wr_valid = i[0];
         wr_data = 8'($urandom);
         seen = seen | wr_ready | busy | load_done;
      end
      wr_valid = 1'b0;
      n_checks++;
      if (seen !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_no_accept: got status activity %b expected 0", seen);
      end
   endtask

   task automatic check_all_words(input string tag);
      logic [47:0] d;
      for (int a = 0; a < DEPTH; a++) begin
         read_word(5'(a), d);
         n_checks++;
         if (d !== model_mem[a]) begin
            n_errors++;
            $display("FAIL %s_word%0d: got %h expected %h", tag, a, d, model_mem[a]);
         end
      end
   endtask

   task automatic check_done(input string tag, input bit early, input bit tmo);
      n_checks++;
      if ({tmo, early} !== 2'b00) begin
         n_errors++;
         $display("FAIL %s_stream: got timeout/early_done=%b expected 00", tag, {tmo, early});
      end
      n_checks++;
      if ({load_done, busy, wr_ready} !== 3'b100) begin
         n_errors++;
         $display("FAIL %s_done: got done/busy/ready=%b expected 100", tag, {load_done, busy, wr_ready});
      end
   endtask

   task automatic test_full_load();
      int cyc; bit early, tmo;
      logic [47:0] d;
      for (int i = 0; i < NBYTES; i++) img[i] = 8'(i);
      pulse_start();
      n_checks++;
      if ({busy, wr_ready, load_done} !== 3'b110) begin
         n_errors++;
         $display("FAIL start_latency: got busy/ready/done=%b expected 110", {busy, wr_ready, load_done});
      end
      send_stream(0, NBYTES, 100, cyc, early, tmo);
      n_checks++;
      if (cyc !== NBYTES) begin
         n_errors++;
         $display("FAIL full_cycles: got %0d expected %0d", cyc, NBYTES);
      end
      check_done("full", early, tmo);
      read_word(5'd0, d);
      n_checks++;
      if (d !== 48'h050403020100) begin
         n_errors++;
         $display("FAIL full_addr0: got %h expected 050403020100", d);
      end
      read_word(5'd24, d);
      n_checks++;
      if (d !== 48'h959493929190) begin
         n_errors++;
         $display("FAIL full_addr24: got %h expected 959493929190", d);
      end
      check_all_words("full");
   endtask

   task automatic test_throttled();
      int cyc; bit early, tmo, seen;
      for (int i = 0; i < NBYTES; i++) img[i] = 8'(i);
      pulse_start();
      send_stream(0, NBYTES, 60, cyc, early, tmo);
      check_done("throttle", early, tmo);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         wr_valid = 1'b1;
         wr_data = 8'hEE;
         seen = seen | wr_ready;
      end
      @(negedge clk);
      wr_valid = 1'b0;
      n_checks++;
      if ({seen, load_done} !== 2'b01) begin
         n_errors++;
         $display("FAIL throttle_overflow: got ready_seen/done=%b expected 01", {seen, load_done});
      end
      check_all_words("throttle");
   endtask

   task automatic test_oob_collision();
      logic [47:0] d, old_w;
      int idx, guard, cyc; bit early, tmo;
      read_word(5'd25, d);
      n_checks++;
      if (d !== 48'h0) begin
         n_errors++;
         $display("FAIL oob_addr25: got %h expected 0", d);
      end
      read_word(5'd31, d);
      n_checks++;
      if (d !== 48'h0) begin
         n_errors++;
         $display("FAIL oob_addr31: got %h expected 0", d);
      end
      for (int i = 0; i < NBYTES; i++) img[i] = 8'(i) ^ 8'hA5;
      old_w = model_mem[3];
      pulse_start();
      idx = 0;
      guard = 0;
      while (idx < 24 && guard < 200) begin
         @(negedge clk);
         guard++;
         wr_valid = 1'b1;
         wr_data = img[idx];
         w1_raddr = (idx == 23) ? 5'd3 : 5'd0;
         if (wr_ready) begin
            model_accept(img[idx]);
            idx++;
         end
      end
      @(negedge clk);
      wr_valid = 1'b0;
      d = {w1_6_rdata, w1_5_rdata, w1_4_rdata, w1_3_rdata, w1_2_rdata, w1_1_rdata};
      n_checks++;
      if (d !== old_w) begin
         n_errors++;
         $display("FAIL collide_old: got %h expected %h", d, old_w);
      end
      @(negedge clk);
      d = {w1_6_rdata, w1_5_rdata, w1_4_rdata, w1_3_rdata, w1_2_rdata, w1_1_rdata};
      n_checks++;
      if (d !== model_mem[3]) begin
         n_errors++;
         $display("FAIL collide_new: got %h expected %h", d, model_mem[3]);
      end
      send_stream(24, NBYTES, 100, cyc, early, tmo);
      check_done("collide", early, tmo);
      check_all_words("collide");
   endtask

   task automatic test_reset_midload();
      int cyc; bit early, tmo;
      logic [47:0] d;
      for (int i = 0; i < NBYTES; i++) img[i] = 8'(i) ^ 8'h3C;
      pulse_start();
      send_stream(0, 40, 70, cyc, early, tmo);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      grp_q.delete();
      n_checks++;
      if ({wr_ready, busy, load_done} !== 3'b000) begin
         n_errors++;
         $display("FAIL midreset_status: got ready/busy/done=%b expected 000", {wr_ready, busy, load_done});
      end
      read_word(5'd5, d);
      n_checks++;
      if (d !== model_mem[5]) begin
         n_errors++;
         $display("FAIL midreset_word5: got %h expected %h", d, model_mem[5]);
      end
      read_word(5'd6, d);
      n_checks++;
      if (d !== model_mem[6]) begin
         n_errors++;
         $display("FAIL midreset_word6_kept: got %h expected %h", d, model_mem[6]);
      end
      for (int i = 0; i < NBYTES; i++) img[i] = 8'hFF - 8'(i);
      pulse_start();
      send_stream(0, NBYTES, 100, cyc, early, tmo);
      check_done("ffreload", early, tmo);
      check_all_words("ffreload");
   endtask

   task automatic test_reload_from_done();
      int cyc; bit early, tmo;
      for (int i = 0; i < NBYTES; i++) img[i] = 8'($urandom);
      pulse_start();
      n_checks++;
      if ({busy, load_done, wr_ready} !== 3'b101) begin
         n_errors++;
         $display("FAIL reload_start: got busy/done/ready=%b expected 101", {busy, load_done, wr_ready});
      end
      send_stream(0, 60, 80, cyc, early, tmo);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({busy, load_done} !== 2'b10) begin
         n_errors++;
         $display("FAIL reload_midstart: got busy/done=%b expected 10", {busy, load_done});
      end
      send_stream(60, NBYTES, 100, cyc, early, tmo);
      n_checks++;
      if (cyc !== 90) begin
         n_errors++;
         $display("FAIL reload_cycles: got %0d expected 90", cyc);
      end
      check_done("reload", early, tmo);
      check_all_words("reload");
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_throttled();
      test_oob_collision();
      test_reset_midload();
      test_reload_from_done();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
